logit_argmax_classifier: RTL

- Final stage of the CIFAR-10 inference chain, directly downstream of the 128-to-10 dense layer.
- Launches the dense stage and waits for its done.
- Scans the 10 signed 32-bit logits through the dense stage's read port and registers the winning class index and score.
- Provides a single-pulse start / sticky done interface to the SoC control logic.

---
 rtl/classifier_pkg.sv | 19 +
 rtl/argmax_update.sv | 52 +++++
 rtl/logit_argmax_classifier.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/classifier_pkg.sv
// Shared constants and FSM state type for the logit argmax classifier.
// The optional runner-up / confidence datapath is enabled by CLASSIFY_MARGIN_EN.
package classifier_pkg;

  localparam int NUM_CLASSES   = 10;
  localparam int DATA_W        = 32;
  localparam int IDX_W         = 4;
  localparam int MARGIN_THRESH = 256;

  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PREV = 2'd1,
    SCAN      = 2'd2,
    DONE      = 2'd3
  } cls_state_t;

endpackage

// File: rtl/argmax_update.sv
// Combinational best/second-best update for one candidate logit (strict greater-than).
// Second-best ports exist only when CLASSIFY_MARGIN_EN is defined.
module argmax_update
  import classifier_pkg::*;
(
  input  logic                     init,
  input  logic signed [DATA_W-1:0] cand_score,
  input  logic [IDX_W-1:0]         cand_idx,
  input  logic signed [DATA_W-1:0] best_score,
  input  logic [IDX_W-1:0]         best_idx,
  output logic signed [DATA_W-1:0] next_best_score,
  output logic [IDX_W-1:0]         next_best_idx
`ifdef CLASSIFY_MARGIN_EN
  ,
  input  logic signed [DATA_W-1:0] second_score,
  input  logic [IDX_W-1:0]         second_idx,
  output logic signed [DATA_W-1:0] next_second_score,
  output logic [IDX_W-1:0]         next_second_idx
`endif
);

  // Ties never replace, so the lower index is kept for both best and second.
  always_comb begin
    next_best_score = best_score;
    next_best_idx   = best_idx;
`ifdef CLASSIFY_MARGIN_EN
    next_second_score = second_score;
    next_second_idx   = second_idx;
`endif
    if (init) begin
      next_best_score = cand_score;
      next_best_idx   = cand_idx;
`ifdef CLASSIFY_MARGIN_EN
      next_second_score = MOST_NEG;
      next_second_idx   = {IDX_W{1'b0}};
`endif
    end else if (cand_score > best_score) begin
      next_best_score = cand_score;
      next_best_idx   = cand_idx;
`ifdef CLASSIFY_MARGIN_EN
      next_second_score = best_score;
      next_second_idx   = best_idx;
    end else if (cand_score > second_score) begin
      next_second_score = cand_score;
      next_second_idx   = cand_idx;
`endif
    end else begin
      next_best_score = best_score;
    end
  end

endmodule

// File: rtl/logit_argmax_classifier.sv
// Launches the dense stage, scans its logits one per cycle and registers the argmax.
// Optional runner-up/margin/low-confidence outputs are enabled by CLASSIFY_MARGIN_EN.
module logit_argmax_classifier
  import classifier_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              dense_start,
  input  logic              dense_done,
  output logic [IDX_W-1:0]  dense_read_addr,
  input  logic [DATA_W-1:0] dense_read_data,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_score,
  output logic [IDX_W-1:0]  runner_up_idx,
  output logic [DATA_W:0]   margin,
  output logic              low_conf,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  cls_state_t               state;
  logic signed [DATA_W-1:0] best_score;
  logic [IDX_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] next_best_score;
  logic [IDX_W-1:0]         next_best_idx;
  logic                     scan_init;

  assign scan_init = (dense_read_addr == {IDX_W{1'b0}});

`ifdef CLASSIFY_MARGIN_EN
  logic signed [DATA_W-1:0] second_score;
  logic [IDX_W-1:0]         second_idx;
  logic signed [DATA_W-1:0] next_second_score;
  logic [IDX_W-1:0]         next_second_idx;
  logic [DATA_W:0]          margin_next;

  // Best >= second always holds, so the sign-extended difference is non-negative.
  assign margin_next = {next_best_score[DATA_W-1], next_best_score}
                     - {next_second_score[DATA_W-1], next_second_score};

  argmax_update u_update (
    .init              (scan_init),
    .cand_score        (dense_read_data),
    .cand_idx          (dense_read_addr),
    .best_score        (best_score),
    .best_idx          (best_idx),
    .next_best_score   (next_best_score),
    .next_best_idx     (next_best_idx),
    .second_score      (second_score),
    .second_idx        (second_idx),
    .next_second_score (next_second_score),
    .next_second_idx   (next_second_idx)
  );

  // Runner-up tracking and the confidence outputs, published only at scan end.
  always_ff @(posedge clk) begin
    if (reset) begin
      second_score  <= {DATA_W{1'b0}};
      second_idx    <= {IDX_W{1'b0}};
      runner_up_idx <= {IDX_W{1'b0}};
      margin        <= {(DATA_W+1){1'b0}};
      low_conf      <= 1'b0;
    end else if (state == SCAN) begin
      second_score <= next_second_score;
      second_idx   <= next_second_idx;
      if (dense_read_addr == LAST_IDX) begin
        runner_up_idx <= next_second_idx;
        margin        <= margin_next;
        low_conf      <= (margin_next < (DATA_W+1)'(MARGIN_THRESH));
      end
    end
  end
`else
  argmax_update u_update (
    .init            (scan_init),
    .cand_score      (dense_read_data),
    .cand_idx        (dense_read_addr),
    .best_score      (best_score),
    .best_idx        (best_idx),
    .next_best_score (next_best_score),
    .next_best_idx   (next_best_idx)
  );

  assign runner_up_idx = {IDX_W{1'b0}};
  assign margin        = {(DATA_W+1){1'b0}};
  assign low_conf      = 1'b0;
`endif

  // Control FSM, read address and the registered argmax result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      dense_start     <= 1'b0;
      dense_read_addr <= {IDX_W{1'b0}};
      best_score      <= {DATA_W{1'b0}};
      best_idx        <= {IDX_W{1'b0}};
      class_idx       <= {IDX_W{1'b0}};
      class_score     <= {DATA_W{1'b0}};
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      dense_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dense_start <= 1'b1;
            busy        <= 1'b1;
            state       <= WAIT_PREV;
          end
        end
        WAIT_PREV: begin
          if (dense_done) begin
            dense_read_addr <= {IDX_W{1'b0}};
            state           <= SCAN;
          end
        end
        SCAN: begin
          best_score <= next_best_score;
          best_idx   <= next_best_idx;
          if (dense_read_addr == LAST_IDX) begin
            class_idx   <= next_best_idx;
            class_score <= next_best_score;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            dense_read_addr <= dense_read_addr + IDX_W'(1);
          end
        end
        DONE: begin
          if (start) begin
            done        <= 1'b0;
            dense_start <= 1'b1;
            busy        <= 1'b1;
            state       <= WAIT_PREV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
